regfile_wb: RTL and testbench

- Register-file responder for the decode stage.
- Accepts the rs/rt read addresses and the resolved destination register from decode, and accepts writeback traffic from the WB stage.
- Returns registered operand data to EX.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards. Hazard detection and the write port live in one block at the far end of the decode interface.

---
 rtl/regfile_wb_pkg.sv | 25 ++
 rtl/regfile_wb_checker.sv | 10 +
 rtl/regfile_wb_scoreboard.sv | 79 +++++++
 rtl/regfile_wb.sv | 106 ++++++++++
 tb/tb_regfile_wb.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared defaults for the decode-side register file (regfile_wb).
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read bypass, early stall release).
package regfile_wb_pkg;

  localparam int DEPTH_BITS_DEF = 5;
  localparam int WIDTH_DEF      = 32;
  localparam int CNT_BITS_DEF   = 2;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Instruction register-index fields.
  function automatic logic [4:0] field_rs(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] field_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] field_rd(input logic [31:0] instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/regfile_wb_checker.sv
// Protocol checks for regfile_wb: writebacks must match an outstanding issue.
module regfile_wb_checker (
  input logic clk,
  input logic reset,
  input logic underflow
);

  wb_without_issue_a: assert property (@(posedge clk) disable iff (reset) !underflow);

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Per-register outstanding-write counters and busy/full lookup for regfile_wb.
// Optional feature macro: REGFILE_BYPASS_EN (final writeback clears busy in the same cycle).
module regfile_wb_scoreboard #(
  parameter int DEPTH_BITS = 5,
  parameter int CNT_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_en,
  input  logic [DEPTH_BITS-1:0] inc_dest,
  input  logic                  dec_en,
  input  logic [DEPTH_BITS-1:0] dec_dest,
  input  logic [DEPTH_BITS-1:0] rs,
  input  logic [DEPTH_BITS-1:0] rt,
  output logic                  busy_rs,
  output logic                  busy_rt,
  output logic                  full_dest,
  output logic                  underflow
);

  localparam int NREGS = 1 << DEPTH_BITS;
  localparam logic [CNT_BITS-1:0]   CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0]   CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0]   CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [DEPTH_BITS-1:0] RZERO    = {DEPTH_BITS{1'b0}};

  logic [CNT_BITS-1:0] cnt_r     [NREGS];
  logic [CNT_BITS-1:0] cnt_nxt_s [NREGS];
  logic [NREGS-1:0]    underflow_s;

  // Next count: +1 on issue, -1 on writeback, hold when both; register 0 never tracked.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt_s[i]   = cnt_r[i];
      underflow_s[i] = 1'b0;
      if (i != 0) begin
        case ({inc_en && (inc_dest == DEPTH_BITS'(i)), dec_en && (dec_dest == DEPTH_BITS'(i))})
          2'b10: begin
            if (cnt_r[i] != CNT_MAX) cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            else                     cnt_nxt_s[i] = cnt_r[i];
          end
          2'b01: begin
            if (cnt_r[i] != CNT_ZERO) cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
            else                      underflow_s[i] = 1'b1;
          end
          default: cnt_nxt_s[i] = cnt_r[i];
        endcase
      end else begin
        cnt_nxt_s[i] = CNT_ZERO;
      end
    end
  end

  // Counter array register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset) cnt_r[i] <= CNT_ZERO;
      else       cnt_r[i] <= cnt_nxt_s[i];
    end
  end

  // Busy lookup for both source operands.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    busy_rs = (cnt_r[rs] != CNT_ZERO) && !(dec_en && (dec_dest == rs) && (cnt_r[rs] == CNT_ONE));
    busy_rt = (cnt_r[rt] != CNT_ZERO) && !(dec_en && (dec_dest == rt) && (cnt_r[rt] == CNT_ONE));
`else
    busy_rs = (cnt_r[rs] != CNT_ZERO);
    busy_rt = (cnt_r[rt] != CNT_ZERO);
`endif
  end

  // Overflow guard on the destination decode wants to issue to.
  assign full_dest = (inc_dest != RZERO) && (cnt_r[inc_dest] == CNT_MAX);

  // Writeback to a register with nothing in flight.
  assign underflow = |underflow_s;

endmodule

// File: rtl/regfile_wb.sv
// Decode-stage register file: 2 registered read ports, 1 writeback port, RAW scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle writeback forwarded into the read).
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH_BITS = DEPTH_BITS_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int CNT_BITS   = CNT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEPTH_BITS-1:0] rs,
  input  logic [DEPTH_BITS-1:0] rt,
  input  logic                  readEn,
  output logic [WIDTH-1:0]      rsData,
  output logic [WIDTH-1:0]      rtData,
  input  logic                  issueEn,
  input  logic [DEPTH_BITS-1:0] issueDest,
  input  logic                  wbEn,
  input  logic [DEPTH_BITS-1:0] wbDest,
  input  logic [WIDTH-1:0]      wbData,
  output logic                  stall
);

  localparam int NREGS = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS-1:0] RZERO = {DEPTH_BITS{1'b0}};
  localparam logic [WIDTH-1:0]      WZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] regs_r [NREGS];
  logic [WIDTH-1:0] rs_val_s;
  logic [WIDTH-1:0] rt_val_s;
  logic             wb_live_s;
  logic             issue_live_s;
  logic             busy_rs_s;
  logic             busy_rt_s;
  logic             full_dest_s;
  logic             underflow_s;

  assign wb_live_s = wbEn && (wbDest != RZERO);

  // Stall on a pending source or a saturated destination counter.
  assign stall = ((rs != RZERO) && busy_rs_s) || ((rt != RZERO) && busy_rt_s) || full_dest_s;

  // An issue during stall is dropped so the counter can never wrap.
  assign issue_live_s = issueEn && !stall;

  regfile_wb_scoreboard #(
    .DEPTH_BITS (DEPTH_BITS),
    .CNT_BITS   (CNT_BITS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .inc_en    (issue_live_s),
    .inc_dest  (issueDest),
    .dec_en    (wbEn),
    .dec_dest  (wbDest),
    .rs        (rs),
    .rt        (rt),
    .busy_rs   (busy_rs_s),
    .busy_rt   (busy_rt_s),
    .full_dest (full_dest_s),
    .underflow (underflow_s)
  );

  regfile_wb_checker u_checker (
    .clk       (clk),
    .reset     (reset),
    .underflow (underflow_s)
  );

  // Storage write port; register 0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= WZERO;
    end else if (wb_live_s) begin
      regs_r[wbDest] <= wbData;
    end
  end

  // Operand lookup with register 0 hardwired to zero.
  always_comb begin
    if (rs == RZERO) rs_val_s = WZERO;
`ifdef REGFILE_BYPASS_EN
    else if (wb_live_s && (wbDest == rs)) rs_val_s = wbData;
`endif
    else rs_val_s = regs_r[rs];

    if (rt == RZERO) rt_val_s = WZERO;
`ifdef REGFILE_BYPASS_EN
    else if (wb_live_s && (wbDest == rt)) rt_val_s = wbData;
`endif
    else rt_val_s = regs_r[rt];
  end

  // Registered operands to EX; hold when decode is not advancing.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsData <= WZERO;
      rtData <= WZERO;
    end else if (readEn) begin
      rsData <= rs_val_s;
      rtData <= rt_val_s;
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus randomized traffic vs a reference model.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs, rt, issueDest, wbDest;
  logic        readEn, issueEn, wbEn;
  logic [31:0] wbData, rsData, rtData;
  logic        stall;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural values, in-flight write counts, expected operands.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic [31:0] exp_rs = 32'd0;
  logic [31:0] exp_rt = 32'd0;

  always #5 clk = ~clk;

  regfile_wb dut (
    .clk       (clk),
    .reset     (reset),
    .rs        (rs),
    .rt        (rt),
    .readEn    (readEn),
    .rsData    (rsData),
    .rtData    (rtData),
    .issueEn   (issueEn),
    .issueDest (issueDest),
    .wbEn      (wbEn),
    .wbDest    (wbDest),
    .wbData    (wbData),
    .stall     (stall)
  );

  function automatic bit m_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    return (m_cnt[r] != 0) && !(wbEn && (wbDest == r) && (m_cnt[r] == 1));
`else
    return m_cnt[r] != 0;
`endif
  endfunction

  function automatic bit m_stall();
    return m_busy(rs) || m_busy(rt) || ((issueDest != 5'd0) && (m_cnt[issueDest] == 3));
  endfunction

  task automatic idle();
    reset = 1'b0; rs = 5'd0; rt = 5'd0; readEn = 1'b0;
    issueEn = 1'b0; issueDest = 5'd0; wbEn = 1'b0; wbDest = 5'd0; wbData = 32'd0;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    bit st;
    st = m_stall();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_cnt[i]  = 0;
      end
      exp_rs = 32'd0;
      exp_rt = 32'd0;
    end else begin
      if (readEn) begin
        exp_rs = (rs == 5'd0) ? 32'd0 : m_regs[rs];
        exp_rt = (rt == 5'd0) ? 32'd0 : m_regs[rt];
`ifdef REGFILE_BYPASS_EN
        if (wbEn && (wbDest != 5'd0) && (wbDest == rs)) exp_rs = wbData;
        if (wbEn && (wbDest != 5'd0) && (wbDest == rt)) exp_rt = wbData;
`endif
      end
      if (wbEn && (wbDest != 5'd0)) m_regs[wbDest] = wbData;
      if (issueEn && !st && (issueDest != 5'd0)) m_cnt[issueDest]++;
      if (wbEn && (wbDest != 5'd0) && (m_cnt[wbDest] > 0)) m_cnt[wbDest]--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle(); reset = 1'b1;
    tick();
    idle(); #1;
    checks++; if (rsData !== 32'd0) begin errors++; $display("FAIL reset_rsdata: got %h want %h", rsData, 32'd0); end
    checks++; if (rtData !== 32'd0) begin errors++; $display("FAIL reset_rtdata: got %h want %h", rtData, 32'd0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    readEn = 1'b1; rs = 5'd5; rt = 5'd0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL read_after_reset_stall: got %b want 0", stall); end
    tick();
    checks++; if (rsData !== 32'd0) begin errors++; $display("FAIL read_r5_after_reset: got %h want %h", rsData, 32'd0); end
    checks++; if (rtData !== 32'd0) begin errors++; $display("FAIL read_r0_after_reset: got %h want %h", rtData, 32'd0); end
  endtask

  task automatic test_write_read();
    idle(); issueEn = 1'b1; issueDest = 5'd7;
    tick();
    idle(); wbEn = 1'b1; wbDest = 5'd7; wbData = 32'hDEADBEEF;
    tick();
    idle(); readEn = 1'b1; rs = 5'd7; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL write_read_stall: got %b want 0", stall); end
    tick();
    checks++; if (rsData !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read_r7: got %h want %h", rsData, 32'hDEADBEEF); end
  endtask

  task automatic test_reg_zero();
    idle(); wbEn = 1'b1; wbDest = 5'd0; wbData = 32'h00001234;
    tick();
    idle(); readEn = 1'b1; rs = 5'd0; rt = 5'd0;
    tick();
    checks++; if (rsData !== 32'd0) begin errors++; $display("FAIL r0_write_dropped_rs: got %h want %h", rsData, 32'd0); end
    checks++; if (rtData !== 32'd0) begin errors++; $display("FAIL r0_write_dropped_rt: got %h want %h", rtData, 32'd0); end
    idle(); issueEn = 1'b1; issueDest = 5'd0;
    repeat (4) tick();
    idle(); issueDest = 5'd0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_not_scoreboarded: got %b want 0", stall); end
  endtask

  task automatic test_raw_stall();
    logic exp_wb_stall;
`ifdef REGFILE_BYPASS_EN
    exp_wb_stall = 1'b0;
`else
    exp_wb_stall = 1'b1;
`endif
    idle(); issueEn = 1'b1; issueDest = 5'd9;
    tick();
    idle(); rs = 5'd9; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_pending_stall: got %b want 1", stall); end
    tick();
    idle(); rs = 5'd9; readEn = 1'b1; wbEn = 1'b1; wbDest = 5'd9; wbData = 32'h00000055; #1;
    checks++; if (stall !== exp_wb_stall) begin errors++; $display("FAIL raw_wb_cycle_stall: got %b want %b", stall, exp_wb_stall); end
    tick();
`ifdef REGFILE_BYPASS_EN
    checks++; if (rsData !== 32'h00000055) begin errors++; $display("FAIL raw_bypass_data: got %h want %h", rsData, 32'h00000055); end
`else
    checks++; if (rsData !== 32'd0) begin errors++; $display("FAIL raw_old_value: got %h want %h", rsData, 32'd0); end
    idle(); rs = 5'd9; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_release_stall: got %b want 0", stall); end
    readEn = 1'b1;
    tick();
    checks++; if (rsData !== 32'h00000055) begin errors++; $display("FAIL raw_reread_data: got %h want %h", rsData, 32'h00000055); end
`endif
  endtask

  task automatic test_overflow();
    idle(); issueEn = 1'b1; issueDest = 5'd3;
    repeat (3) tick();
    idle(); issueDest = 5'd3; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL overflow_full_stall: got %b want 1", stall); end
    issueEn = 1'b1;
    tick();
    idle(); issueDest = 5'd3; wbEn = 1'b1; wbDest = 5'd3; wbData = 32'h00000033;
    tick();
    idle(); issueDest = 5'd3; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL overflow_after_one_wb: got %b want 0", stall); end
    issueEn = 1'b1; wbEn = 1'b1; wbDest = 5'd3; wbData = 32'h00000034;
    tick();
    idle(); issueEn = 1'b1; issueDest = 5'd3;
    tick();
    idle(); issueDest = 5'd3; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL overflow_simul_unchanged: got %b want 1", stall); end
    for (int k = 0; k < 3; k++) begin
      idle(); rs = 5'd3; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL drain_busy_%0d: got %b want 1", k, stall); end
      wbEn = 1'b1; wbDest = 5'd3; wbData = 32'h00000040 + 32'(k);
      tick();
    end
    idle(); rs = 5'd3; issueDest = 5'd3; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL drain_released: got %b want 0", stall); end
  endtask

  task automatic test_reset_mid();
    idle(); issueEn = 1'b1; issueDest = 5'd4;
    repeat (3) tick();
    idle(); wbEn = 1'b1; wbDest = 5'd4; wbData = 32'hA5A50004;
    tick();
    idle(); readEn = 1'b1; rs = 5'd7; rt = 5'd7;
    tick();
    checks++; if (rsData !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_read: got %h want %h", rsData, 32'hDEADBEEF); end
    idle(); reset = 1'b1; wbEn = 1'b1; wbDest = 5'd4; wbData = 32'h11112222;
    tick();
    idle(); #1;
    checks++; if (rsData !== 32'd0) begin errors++; $display("FAIL midreset_rsdata: got %h want %h", rsData, 32'd0); end
    checks++; if (rtData !== 32'd0) begin errors++; $display("FAIL midreset_rtdata: got %h want %h", rtData, 32'd0); end
    rs = 5'd4; issueDest = 5'd4; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midreset_cnt_cleared: got %b want 0", stall); end
    readEn = 1'b1;
    tick();
    checks++; if (rsData !== 32'd0) begin errors++; $display("FAIL midreset_r4_cleared: got %h want %h", rsData, 32'd0); end
  endtask

  task automatic test_random();
    int pend[$];
    int idx;
    for (int n = 0; n < 600; n++) begin
      idle();
      reset     = ($urandom_range(0, 99) == 0);
      rs        = 5'($urandom_range(0, 7));
      rt        = 5'($urandom_range(0, 7));
      issueDest = 5'($urandom_range(0, 7));
      readEn    = 1'($urandom_range(0, 1));
      issueEn   = 1'($urandom_range(0, 1));
      wbData    = $urandom;
      pend.delete();
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend.push_back(r);
      if ((pend.size() > 0) && ($urandom_range(0, 2) != 0)) begin
        idx    = int'($urandom_range(0, pend.size() - 1));
        wbEn   = 1'b1;
        wbDest = 5'(pend[idx]);
      end else if ($urandom_range(0, 7) == 0) begin
        wbEn   = 1'b1;
        wbDest = 5'd0;
      end else begin
        wbDest = 5'($urandom_range(0, 31));
      end
      #1;
      checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rand_stall[%0d]: got %b want %b", n, stall, m_stall()); end
      tick();
      checks++; if (rsData !== exp_rs) begin errors++; $display("FAIL rand_rsdata[%0d]: got %h want %h", n, rsData, exp_rs); end
      checks++; if (rtData !== exp_rt) begin errors++; $display("FAIL rand_rtdata[%0d]: got %h want %h", n, rtData, exp_rt); end
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_reg_zero();
    test_raw_stall();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
